// File: rtl/pushbutton_led_counter.sv
// Pushbutton up/down LED counter: two raw buttons are synchronised,
// debounced and edge-detected; each accepted press steps an 8-bit count.
//
// Ports:
//   CLK     in  1  system clock (12 MHz)
//   BTN     in  1  synchronous active-high reset
//   PB_UP   in  1  raw up button, asynchronous, 1 = pressed
//   PB_DN   in  1  raw down button, asynchronous, 1 = pressed
//   LED_OUT out 8  current count, registered, [7] is MSB
//   STEP    out 1  one-cycle pulse on each edge where LED_OUT changes
//
// Optional macro AUTO_REPEAT_EN: hold-to-repeat after HOLD_CYCLES, then
// every REPEAT_CYCLES while the button stays pressed.

module pushbutton_led_counter #(
  parameter int CLK_FREQ        = 12_000_000,
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int HOLD_CYCLES     = 6_000_000,
  parameter int REPEAT_CYCLES   = 1_200_000
) (
  input  logic       CLK,
  input  logic       BTN,
  input  logic       PB_UP,
  input  logic       PB_DN,
  output logic [7:0] LED_OUT,
  output logic       STEP
);

  if (CLK_FREQ < 1 || DEBOUNCE_CYCLES < 2 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("pushbutton_led_counter: illegal parameter value");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DC_MAX = DW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = up, channel 1 = down.
  logic [1:0]         w_raw;
  logic [1:0]         r_s1;
  logic [1:0]         r_s2;
  logic [1:0]         r_st;
  logic [1:0][DW-1:0] r_dc;
  logic [1:0]         w_flip;
  logic [1:0]         w_press;
  logic [1:0]         w_rel;
  logic [1:0]         w_ev;

  assign w_raw = {PB_DN, PB_UP};

`ifdef AUTO_REPEAT_EN
  localparam int MAXC =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(MAXC + 1);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_M1  = HW'(REPEAT_CYCLES - 1);

  logic [1:0][HW-1:0] r_hc;
  // r_ph: 0 = waiting for the initial hold, 1 = repeating
  logic [1:0]         r_ph;
  logic [1:0]         w_rep;
`endif

  always_comb begin
    w_flip  = '0;
    w_press = '0;
    w_rel   = '0;
    w_ev    = '0;
`ifdef AUTO_REPEAT_EN
    w_rep   = '0;
`endif
    for (int i = 0; i < 2; i++) begin
      w_flip[i]  = (r_s2[i] != r_st[i]) && (r_dc[i] == DC_MAX);
      w_press[i] = w_flip[i] && !r_st[i];
      w_rel[i]   = w_flip[i] &&  r_st[i];
`ifdef AUTO_REPEAT_EN
      w_rep[i]   = r_st[i] && !w_rel[i] &&
                   (r_ph[i] ? (r_hc[i] == REP_M1)
                            : (r_hc[i] == HOLD_M1));
      w_ev[i]    = w_press[i] || w_rep[i];
`else
      w_ev[i]    = w_press[i];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (BTN) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_st    <= '0;
      r_dc    <= '0;
      LED_OUT <= '0;
      STEP    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_hc    <= '0;
      r_ph    <= '0;
`endif
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_st[i]) begin
          r_dc[i] <= '0;
        end else if (w_flip[i]) begin
          r_st[i] <= r_s2[i];
          r_dc[i] <= '0;
        end else begin
          r_dc[i] <= r_dc[i] + 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        // Counts from the press step; cleared while released.
        if (!r_st[i] || w_rel[i]) begin
          r_hc[i] <= '0;
          r_ph[i] <= 1'b0;
        end else if (w_rep[i]) begin
          r_hc[i] <= '0;
          r_ph[i] <= 1'b1;
        end else begin
          r_hc[i] <= r_hc[i] + 1'b1;
        end
`endif
      end
      // Simultaneous up and down events cancel.
      unique case ({w_ev[1], w_ev[0]})
        2'b01: begin
          LED_OUT <= LED_OUT + 8'd1;
          STEP    <= 1'b1;
        end
        2'b10: begin
          LED_OUT <= LED_OUT - 8'd1;
          STEP    <= 1'b1;
        end
        default: STEP <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pushbutton_led_counter.sv
// Scoreboard bench for pushbutton_led_counter: directed presses push
// expected (cycle, LED) steps; a monitor pops them on every STEP pulse.

module tb_pushbutton_led_counter;

  logic       CLK = 1'b0;
  logic       BTN = 1'b0;
  logic       PB_UP = 1'b0;
  logic       PB_DN = 1'b0;
  logic [7:0] LED_OUT;
  logic       STEP;

  pushbutton_led_counter #(
    .CLK_FREQ       (12_000_000),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .CLK    (CLK),
    .BTN    (BTN),
    .PB_UP  (PB_UP),
    .PB_DN  (PB_DN),
    .LED_OUT(LED_OUT),
    .STEP   (STEP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [7:0] led;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  logic       btn_q = 1'b0;
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_led = '0;
  logic [7:0] model = '0;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    btn_q <= BTN;
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_step: expected at cycle %0d led %0d, no STEP pulse",
                 sb[0].cyc, sb[0].led);
        void'(sb.pop_front());
      end
      if (STEP === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_step: cycle %0d led %0d, no step required",
                   cyc, LED_OUT);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.cyc != cyc || e.led !== LED_OUT) begin
            fails++;
            $display("FAIL step: got cycle %0d led %0d, required cycle %0d led %0d",
                     cyc, LED_OUT, e.cyc, e.led);
          end
        end
      end else if (STEP !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL step_x: cycle %0d STEP=%b, required 0 or 1", cyc, STEP);
      end else if (!btn_q && LED_OUT !== prev_led) begin
        tests++;
        fails++;
        $display("FAIL silent_change: cycle %0d led %0d, required %0d",
                 cyc, LED_OUT, prev_led);
      end
      prev_led = LED_OUT;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(int c, logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.led = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    BTN = 1'b1;
    tick();
    tick();
    BTN = 1'b0;
    model = '0;
    check("reset_led", LED_OUT, 8'd0);
    check("reset_step", {7'd0, STEP}, 8'd0);
  endtask

  // Raw level first sampled at the next edge; step 1+1+4 edges later.
  task automatic press(bit up, bit dn, int hold);
    int n;
    n = cyc;
    PB_UP = up;
    PB_DN = dn;
    if (up && !dn) begin
      model = model + 8'd1;
      push(n + 6, model);
    end else if (dn && !up) begin
      model = model - 8'd1;
      push(n + 6, model);
    end
    repeat (hold) tick();
    PB_UP = 1'b0;
    PB_DN = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int n;
    tick();
    do_reset();
    prev_led = LED_OUT;
    mon_en = 1'b1;

    // 1: clean up press, no step on release
    press(1'b1, 1'b0, 10);
    check("t1_led", LED_OUT, 8'd1);

    // 2: glitch train never reaches the debounce threshold
    do_reset();
    for (int g = 0; g < 5; g++) begin
      PB_UP = 1'b1;
      repeat (3) tick();
      PB_UP = 1'b0;
      tick();
    end
    repeat (10) tick();
    check("t2_glitch_led", LED_OUT, 8'd0);

    // 3: wrap both ways
    press(1'b0, 1'b1, 10);
    check("t3_wrap_down", LED_OUT, 8'd255);
    press(1'b1, 1'b0, 10);
    check("t3_wrap_up", LED_OUT, 8'd0);

    // 4: both buttons with identical bounce cancel
    press(1'b1, 1'b0, 10);
    for (int g = 0; g < 2; g++) begin
      PB_UP = 1'b1;
      PB_DN = 1'b1;
      repeat (2) tick();
      PB_UP = 1'b0;
      PB_DN = 1'b0;
      tick();
    end
    press(1'b1, 1'b1, 10);
    check("t4_both_led", LED_OUT, 8'd1);

    // 5: reset mid-press, held button re-debounced from scratch
    do_reset();
    n = cyc;
    PB_UP = 1'b1;
    push(n + 6, 8'd1);
    repeat (6) tick();
    BTN = 1'b1;
    tick();
    BTN = 1'b0;
    check("t5_reset_clear", LED_OUT, 8'd0);
    push(cyc + 6, 8'd1);
    repeat (7) tick();
    PB_UP = 1'b0;
    repeat (10) tick();
    check("t5_led", LED_OUT, 8'd1);

    // 6: long hold (repeat only with AUTO_REPEAT_EN)
    do_reset();
    n = cyc;
    PB_UP = 1'b1;
    push(n + 6, 8'd1);
`ifdef AUTO_REPEAT_EN
    for (int i = 1; i < 8; i++)
      push(n + 6 + 15 + 5 * i, 8'(i + 1));
`endif
    repeat (52) tick();
    PB_UP = 1'b0;
    repeat (12) tick();
`ifdef AUTO_REPEAT_EN
    check("t6_repeat_led", LED_OUT, 8'd8);
`else
    check("t6_hold_led", LED_OUT, 8'd1);
`endif

    repeat (4) tick();
    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
